// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2, K=3 hard-decision Viterbi decoder:
// code generators, state type and the expected-symbol helper.
package viterbi_pkg;

   localparam int         K          = 3;
   localparam int         NUM_STATES = 4;
   localparam logic [2:0] G0         = 3'b111;
   localparam logic [2:0] G1         = 3'b101;

   typedef logic [1:0] state_t;

   // Encoder shift register is {d, s1, s0}; pair[1] uses G0, pair[0] uses G1.
   function automatic logic [1:0] exp_pair(state_t s, logic d);
      logic [2:0] sr;
      sr = {d, s};
      return {^(sr & G0), ^(sr & G1)};
   endfunction

endpackage

// File: rtl/viterbi_acs.sv
// One add-compare-select half butterfly: picks the cheaper of two predecessor
// candidates; ties resolve to predecessor 0 (the one with s0=0).
module viterbi_acs #(
   parameter int PM_W = 6
) (
   input  logic [PM_W-1:0] pm0,
   input  logic [PM_W-1:0] pm1,
   input  logic [1:0]      bm0,
   input  logic [1:0]      bm1,
   output logic [PM_W-1:0] pm_new,
   output logic            dec
);

   logic [PM_W-1:0] cand0;
   logic [PM_W-1:0] cand1;

   always_comb begin
      cand0  = pm0 + PM_W'(bm0);
      cand1  = pm1 + PM_W'(bm1);
      dec    = (cand1 < cand0);
      pm_new = dec ? cand1 : cand0;
   end

endmodule

// File: rtl/viterbi_decoder.sv
// Register-exchange Viterbi decoder, output TB_DEPTH symbols behind input.
// Optional feature macro VITERBI_METRIC_OUT_EN adds best_pm_o (normalized best metric).
module viterbi_decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH  = 15,
   parameter int PM_W      = 6,
   parameter int INIT_BIAS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable_i,
   input  logic [1:0]      d_in,
   output logic            d_out,
   output logic            valid_o
`ifdef VITERBI_METRIC_OUT_EN
   ,
   output logic [PM_W-1:0] best_pm_o
`endif
);

   localparam int CNT_W = $clog2(TB_DEPTH + 1);

   logic [PM_W-1:0]     pm_p0    [NUM_STATES];
   logic [TB_DEPTH-1:0] path_p0  [NUM_STATES];
   logic [PM_W-1:0]     pm_acs   [NUM_STATES];
   logic [PM_W-1:0]     pm_new   [NUM_STATES];
   logic [TB_DEPTH-1:0] path_new [NUM_STATES];
   logic [1:0]          bm0      [NUM_STATES];
   logic [1:0]          bm1      [NUM_STATES];
   logic [NUM_STATES-1:0] dec;
   logic [CNT_W-1:0]    cnt_p0;
   logic                norm;
   state_t              best;

   function automatic logic [1:0] hamming(logic [1:0] a, logic [1:0] b);
      logic [1:0] x;
      x = a ^ b;
      return {x[1] & x[0], x[1] ^ x[0]};
   endfunction

   // Next state n={d,s1} is reached from {s1,0} and {s1,1}.
   for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
      localparam int   P0 = 2 * (n % 2);
      localparam int   P1 = P0 + 1;
      localparam logic D  = 1'(n / 2);

      assign bm0[n] = hamming(d_in, exp_pair(state_t'(P0), D));
      assign bm1[n] = hamming(d_in, exp_pair(state_t'(P1), D));

      viterbi_acs #(.PM_W(PM_W)) u_acs (
         .pm0    (pm_p0[P0]),
         .pm1    (pm_p0[P1]),
         .bm0    (bm0[n]),
         .bm1    (bm1[n]),
         .pm_new (pm_acs[n]),
         .dec    (dec[n])
      );

      assign path_new[n] = dec[n] ? {path_p0[P1][TB_DEPTH-2:0], D}
                                  : {path_p0[P0][TB_DEPTH-2:0], D};
   end

   // Metric spread stays below half range, so dropping a common MSB keeps order.
   always_comb begin
      norm = 1'b1;
      for (int i = 0; i < NUM_STATES; i++) norm &= pm_acs[i][PM_W-1];
      for (int i = 0; i < NUM_STATES; i++) begin
         pm_new[i] = pm_acs[i];
         if (norm) pm_new[i][PM_W-1] = 1'b0;
      end
      best = '0;
      for (int i = 1; i < NUM_STATES; i++)
         if (pm_new[i] < pm_new[best]) best = state_t'(i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            if (i == 0) pm_p0[i] <= '0;
            else        pm_p0[i] <= PM_W'(INIT_BIAS);
            path_p0[i] <= '0;
         end
         cnt_p0    <= '0;
         d_out     <= 1'b0;
         valid_o   <= 1'b0;
`ifdef VITERBI_METRIC_OUT_EN
         best_pm_o <= '0;
`endif
      end else begin
         valid_o <= 1'b0;
         if (enable_i) begin
            for (int i = 0; i < NUM_STATES; i++) begin
               pm_p0[i]   <= pm_new[i];
               path_p0[i] <= path_new[i];
            end
            if (cnt_p0 != CNT_W'(TB_DEPTH)) cnt_p0 <= cnt_p0 + 1'b1;
            if (cnt_p0 >= CNT_W'(TB_DEPTH - 1)) begin
               d_out     <= path_new[best][TB_DEPTH-1];
               valid_o   <= 1'b1;
`ifdef VITERBI_METRIC_OUT_EN
               best_pm_o <= pm_new[best];
`endif
            end
         end
      end
   end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional encoder.
- It consumes the encoder's 2-bit code symbols and recovers the original serial bit stream.
- Register-exchange survivor storage is used, so output is a fixed TB_DEPTH symbols behind input.
- It sits at the receive end of the encoder/channel path and is bench-compatible with the encoder's enable_i/valid_o handshake.

Code convention (decided):
- Encoder state is {s1,s0}, where s1 is the most recent past input; start state is 0.
- Encoder outputs are pair[1] = d^s1^s0 (G=111) and pair[0] = d^s0 (G=101).
- Next state is {d,s1}.

Parameters:
- TB_DEPTH, 15, survivor/path-register length in bits and decode latency in accepted symbols; legal range 4..32.
- PM_W, 6, path-metric width in bits; minimum 4.
- INIT_BIAS, 4, reset metric for states 1..3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- enable_i  in  1  symbol strobe; d_in is accepted on any rising edge where it is 1.
- d_in  in  2  received code symbol {pair[1],pair[0]}.
- d_out  out  1  decoded bit.
- valid_o  out  1  d_out is valid this cycle (one-cycle pulse per output).

Behaviour:
- Reset (rst=0, async):
  - pm[0]=0 and pm[1..3]=INIT_BIAS.
  - All path registers are 0 and the symbol count is 0.
  - d_out=0 and valid_o=0.
- Idle cycle (enable_i=0): metrics, paths and count hold; valid_o=0; d_out holds its last value.
- Branch metric: Hamming distance (0..2) between d_in and the expected pair for each transition.
- ACS per next state n={d,s1}:
  - Predecessors are {s1,0} and {s1,1}.
  - cand = pm[pred] + bm.
  - Choose the smaller cand; on a tie choose the predecessor with s0=0.
- Normalization: if the MSB of every new metric is 1, clear that MSB in all four metrics in the same cycle. Metrics never wrap.
- Path update: path_new[n] = {path[pred][TB_DEPTH-2:0], d}, where d = n[1].
- Best state: lowest new metric; ties go to the lowest state index. Best state is computed combinationally from the new metrics.
- Count: increments per accepted symbol and saturates at TB_DEPTH.
- Output, on an accepted symbol where count+1 >= TB_DEPTH:
  - d_out <= path_new[best][TB_DEPTH-1], which is the decoded bit of the symbol accepted TB_DEPTH-1 symbols earlier.
  - valid_o <= 1.
  - Otherwise valid_o <= 0.
- Latency:
  - The first valid_o occurs on the edge that accepts symbol number TB_DEPTH, so it is visible the cycle after.
  - After that, exactly one output per accepted symbol, in order.
- Back-to-back enable: full throughput, one symbol per clock.
- Reset mid-stream: all state is discarded immediately, with no residual outputs. The stream restarts at encoder state 0.
- Flush: there is no explicit flush. The source appends TB_DEPTH zero symbols (encoder fed zeros) to drain the decoder.

Optional Feature:
- VITERBI_METRIC_OUT_EN defined:
  - Adds output port best_pm_o [PM_W-1:0], which is the normalized best-state metric.
  - It is registered on the same edge and under the same condition as d_out.
  - Reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package viterbi_pkg holds:
  - Constants K=3, NUM_STATES=4, G0=3'b111, G1=3'b101.
  - Typedef state_t (logic [1:0]).
  - Function exp_pair(state_t s, logic d) returning the 2-bit expected symbol.
- Sub-module viterbi_acs (one ACS butterfly half):
  - Inputs: two predecessor metrics and two branch metrics.
  - Outputs: new metric and decision bit.
  - Instantiated 4x.
- Path registers, normalization, best-state select and output logic live in viterbi_decoder.

Test Plan:
- All-zero stream: 40 symbols of 00 with enable_i=1.
  - valid_o first rises after 15 symbols.
  - d_out=0 throughout; best_pm_o=0.
- Clean sequence: 00 11 10 11 00 11 10 11 11 01 01 11, followed by 15 x 00.
  - 27 symbols fed, 13 outputs produced.
  - Outputs 1..12 are 0,1,0,0,0,1,0,0,1,1,0,0; output 13 is 0.
  - best_pm_o=0 at the end.
- Single bit error: same sequence as the clean case, with symbol 3 changed 10 -> 00.
  - Identical decoded bits.
  - best_pm_o=1 on the final output.
- Enable gaps: the clean sequence with enable_i=0 for 1-3 random cycles between symbols.
  - Same 13 outputs in the same order.
  - valid_o is never high in a gap cycle.
- Reset mid-stream: assert rst=0 after symbol 8 for 2 cycles, then feed the full clean sequence plus flush.
  - valid_o=0 during reset and for the first 14 symbols after it.
  - Decoded bits exactly match the clean case.
- Normalization: 200 symbols of random pairs with PM_W=4.
  - No metric wraps, checked against a reference model with unbounded metrics.
  - Decoded bits match the model.
